onchip_mem_stream_reader: RTL
=============================

// Module: onchip_mem_stream_reader
// PURPOSE
//  Avalon-MM read master that sits directly downstream of the 32-bit single-port on-chip RAM (192 Ki words).
//  Copies a block of words from the RAM to an Avalon-ST source with SOP/EOP framing.
//  The stream feeds the SpaceWire/data-packet transmit path.
//  Reads are credit-limited by an internal FIFO, so the RAM is never read faster than the sink drains.
// PARAMETERS
//  ADDR_W      18      RAM word-address width
//  DATA_W      32      RAM / stream data width
//  MEM_WORDS   196608  RAM depth in words; used for the range check
//  FIFO_DEPTH  4       output FIFO depth in words; power of 2, >= 2
// PORTS
//  clk               in   1       system clock; all logic on rising edge
//  reset_n           in   1       asynchronous, active-low reset
//  start_i           in   1       1-cycle pulse: begin transfer (ignored while busy_o=1)
//  start_addr_i      in   ADDR_W  first word address; sampled on start_i
//  word_cnt_i        in   ADDR_W  number of words; sampled on start_i; 0 is illegal
//  abort_i           in   1       1-cycle pulse: cancel the transfer in progress
//  busy_o            out  1       transfer in progress (RUN or DRAIN)
//  done_o            out  1       1-cycle pulse after the last word is accepted by the sink
//  err_o             out  1       1-cycle pulse: start rejected (count 0 or range overflow)
//  mem_address_o     out  ADDR_W  RAM word address
//  mem_chipselect_o  out  1       RAM select; high only on read-issue cycles
//  mem_write_o       out  1       constant 0
//  mem_byteenable_o  out  4       constant 4'hF
//  mem_clken_o       out  1       constant 1
//  mem_readdata_i    in   DATA_W  RAM read data; valid 1 cycle after issue
//  src_valid_o       out  1       stream word valid
//  src_data_o        out  DATA_W  stream word
//  src_sop_o         out  1       first word of the transfer
//  src_eop_o         out  1       last word of the transfer
//  src_ready_i       in   1       sink ready; a word transfers when valid & ready
// BEHAVIOUR
//  Reset: FSM=IDLE; FIFO empty; all outputs 0 except constants; mem_address_o=0.
//  FSM states
//   IDLE : start_i & word_cnt_i!=0 & start_addr_i+word_cnt_i<=MEM_WORDS (computed ADDR_W+1 bits wide)
//          -> RUN; latch addr/remaining count; clear SOP/EOP tracking.
//          start_i with any other operands -> err_o pulse next cycle; stay IDLE.
//   RUN  : issue one read per cycle while credit is available (credit = in_flight + fifo_count < FIFO_DEPTH).
//          On each issue: address += 1, remaining -= 1. remaining reaches 0 -> DRAIN.
//   DRAIN: no reads issued. FIFO empty & in_flight=0 -> done_o pulse -> IDLE.
//  Read latency: issue in cycle N; mem_readdata_i captured into the FIFO at the edge ending cycle N+1.
//   in_flight is a 1-bit flag.
//  Throughput: 1 word/cycle sustained with src_ready_i=1; first src_valid_o appears 2 cycles after entering RUN.
//  Stream: FIFO is first-word-fall-through; src_data_o holds stable while valid & !ready.
//   SOP is on the first word output; EOP is on word number word_cnt; a 1-word transfer has SOP=EOP=1.
//  FIFO full: issue stalls; no word is ever dropped or overwritten.
//   Simultaneous push and pop on a full FIFO is legal.
//  Address never wraps; the range check guarantees last address <= MEM_WORDS-1.
//  abort_i (RUN/DRAIN): in the next cycle the FIFO is flushed, in_flight data is discarded,
//   src_valid_o=0, FSM=IDLE, no done_o. abort_i in IDLE is ignored.
//  start_i and abort_i in the same cycle while busy: abort wins; the start is ignored.
//  start_i in the same cycle done_o is asserted: ignored (FSM is not yet IDLE).
//  Asynchronous reset mid-transfer: immediate return to reset state; partial stream is abandoned.
// CONFIGURATION
//  ONCHIP_RD_CHKSUM_EN defined: adds output chksum_o [DATA_W].
//   chksum_o is the sum mod 2^DATA_W of every word accepted by the sink (valid & ready).
//   Cleared when a valid start is accepted; held after done_o or abort until the next valid start; reset value 0.
//  ONCHIP_RD_CHKSUM_EN undefined: port and adder are absent; all other behaviour is identical.
// TESTING
//  1 addr=0x00010, cnt=8, RAM[n]=n, ready=1 -> data 0x10..0x17 on 8 consecutive cycles;
//    SOP on 0x10, EOP on 0x17; done_o 1 cycle after the last word; chksum_o=0x9C.
//  2 cnt=1 at addr=0x2FFFF -> single word with SOP=EOP=1, done_o pulse.
//    addr=0x2FFFF, cnt=2 -> err_o pulse, busy_o stays 0, no chipselect.
//  3 cnt=64, ready toggling 1-of-3 cycles -> all 64 words in order, no duplicates;
//    fifo_count never exceeds FIFO_DEPTH; chipselect stalls while credit=0.
//  4 cnt=100, abort_i after 10 words accepted -> next cycle valid=0 and busy=0, no done_o;
//    a following start with addr=0, cnt=4 streams RAM[0..3] cleanly with SOP.
//  5 reset_n low mid-transfer (cnt=50) -> all outputs 0 asynchronously; after release a new start works.
//    start_i while busy -> ignored, counts unchanged.
//  6 word_cnt_i=0 -> err_o pulse; start_i and abort_i together while busy -> abort only, no restart.

Source files
------------

// File: rtl/onchip_mem_stream_reader_if.sv
// onchip_mem_stream_reader_if
// Bus bundle between the stream reader, the on-chip RAM (Avalon-MM read side)
// and the downstream Avalon-ST sink. The master modport is the reader's view.
interface onchip_mem_stream_reader_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
);
  // Avalon-MM RAM side
  logic [ADDR_W-1:0] mem_address_o;
  logic              mem_chipselect_o;
  logic              mem_write_o;
  logic [3:0]        mem_byteenable_o;
  logic              mem_clken_o;
  logic [DATA_W-1:0] mem_readdata_i;

  // Avalon-ST source side
  logic              src_valid_o;
  logic [DATA_W-1:0] src_data_o;
  logic              src_sop_o;
  logic              src_eop_o;
  logic              src_ready_i;

  modport master (
    output mem_address_o,
    output mem_chipselect_o,
    output mem_write_o,
    output mem_byteenable_o,
    output mem_clken_o,
    input  mem_readdata_i,
    output src_valid_o,
    output src_data_o,
    output src_sop_o,
    output src_eop_o,
    input  src_ready_i
  );

  modport slave (
    input  mem_address_o,
    input  mem_chipselect_o,
    input  mem_write_o,
    input  mem_byteenable_o,
    input  mem_clken_o,
    output mem_readdata_i,
    input  src_valid_o,
    input  src_data_o,
    input  src_sop_o,
    input  src_eop_o,
    output src_ready_i
  );
endinterface

// File: rtl/onchip_mem_stream_reader.sv
// onchip_mem_stream_reader
// Avalon-MM read master that copies a block of words from the single-port
// on-chip RAM into an Avalon-ST source with SOP/EOP framing. Reads are issued
// only when the output FIFO plus the word in flight leave room, so the RAM is
// never read faster than the sink drains.
// Optional feature: define ONCHIP_RD_CHKSUM_EN to add chksum_o, the running
// modular sum of every word accepted by the sink.
module onchip_mem_stream_reader #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int MEM_WORDS  = 196608,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    start_addr_i,
  input  logic [ADDR_W-1:0]    word_cnt_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
`ifdef ONCHIP_RD_CHKSUM_EN
  output logic [DATA_W-1:0]    chksum_o,
`endif
  onchip_mem_stream_reader_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // A start is legal when the count is non-zero and the block ends inside the
  // RAM; the sum is one bit wider so an overflowing block cannot alias.
  function automatic logic range_ok(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] cnt);
    logic [ADDR_W:0] end_excl;
    end_excl = {1'b0, addr} + {1'b0, cnt};
    return (cnt != '0) && (end_excl <= (ADDR_W+1)'(MEM_WORDS));
  endfunction

`ifdef ONCHIP_RD_CHKSUM_EN
  // Modular accumulate: carry out of the top bit is dropped on purpose.
  function automatic logic [DATA_W-1:0] chk_add(input logic [DATA_W-1:0] acc,
                                                input logic [DATA_W-1:0] word);
    return acc + word;
  endfunction
`endif

  state_t              state_q;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   remain_q;
  logic [ADDR_W-1:0]   total_q;
  logic [ADDR_W-1:0]   out_cnt_q;
  logic                vld_p1;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    fifo_cnt_q;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic                err_q;

  logic                issue_p0;
  logic                done_c;
  logic                start_ok;
  logic                start_bad;
  logic                abort_c;
  logic                credit_ok;
  logic [CNT_W-1:0]    credit_used;
  logic                push;
  logic                pop;
  logic                src_valid;

  // Credit counts both buffered words and the read whose data is still on the bus.
  assign credit_used = fifo_cnt_q + CNT_W'(vld_p1);
  assign credit_ok   = credit_used < CNT_W'(FIFO_DEPTH);
  assign abort_c     = abort_i && (state_q != IDLE);
  assign src_valid   = (fifo_cnt_q != '0);
  assign pop         = src_valid && bus.src_ready_i;
  assign push        = vld_p1 && !abort_c;

  // FSM next-state and per-cycle strobes
  always_comb begin
    state_nxt = state_q;
    issue_p0  = 1'b0;
    done_c    = 1'b0;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (range_ok(start_addr_i, word_cnt_i)) begin
            start_ok  = 1'b1;
            state_nxt = RUN;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (credit_ok) begin
          issue_p0 = 1'b1;
          if (remain_q == ADDR_W'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_i) begin
          state_nxt = IDLE;
        end else if ((fifo_cnt_q == '0) && !vld_p1) begin
          done_c    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  // ---- stage p0: read issue, address and remaining-count tracking ----
  // Address and counts latch on an accepted start and step on every issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      remain_q <= '0;
      total_q  <= '0;
    end else if (start_ok) begin
      addr_q   <= start_addr_i;
      remain_q <= word_cnt_i;
      total_q  <= word_cnt_i;
    end else if (issue_p0) begin
      addr_q   <= addr_q + ADDR_W'(1);
      remain_q <= remain_q - ADDR_W'(1);
    end
  end

  // ---- stage p1: read data on the bus, captured into the FIFO ----
  // In-flight flag; abort suppresses new issues so the flag clears with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= issue_p0;
  end

  // FIFO pointers and occupancy; abort flushes everything in one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (abort_c) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // FIFO storage; pure data, written only on push.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.mem_readdata_i;
  end

  // ---- stage p2: stream output (first-word-fall-through) ----
  // Position of the next word handed to the sink, for SOP/EOP marking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      out_cnt_q <= '0;
    else if (start_ok) out_cnt_q <= '0;
    else if (pop)      out_cnt_q <= out_cnt_q + ADDR_W'(1);
  end

  // Rejected start reported one cycle after the attempt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= start_bad;
  end

`ifdef ONCHIP_RD_CHKSUM_EN
  // Running sum of accepted words; cleared only by a new accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      chksum_o <= '0;
    else if (start_ok) chksum_o <= '0;
    else if (pop)      chksum_o <= chk_add(chksum_o, bus.src_data_o);
  end
`endif

  assign busy_o = (state_q != IDLE);
  assign done_o = done_c;
  assign err_o  = err_q;

  assign bus.mem_address_o    = addr_q;
  assign bus.mem_chipselect_o = issue_p0;
  assign bus.mem_write_o      = 1'b0;
  assign bus.mem_byteenable_o = 4'hF;
  assign bus.mem_clken_o      = 1'b1;

  // Data is forced to zero while nothing is valid so idle/reset outputs are clean.
  assign bus.src_valid_o = src_valid;
  assign bus.src_data_o  = src_valid ? fifo_mem[rd_ptr_q] : '0;
  assign bus.src_sop_o   = src_valid && (out_cnt_q == '0);
  assign bus.src_eop_o   = src_valid && (out_cnt_q == (total_q - ADDR_W'(1)));

endmodule
